sw_btn_in: RTL and testbench
============================

SW_BTN_IN -- requirements
Module: sw_btn_in

Interface
REQ-001 Parameter DB_CYCLES, default 1000000, number of consecutive clk cycles a synchronized input must hold a new level before the debounced copy adopts it (10 ms at 100 MHz).
REQ-002 Parameter CNT_W, default 20, debounce counter width; SHALL satisfy 2^CNT_W > DB_CYCLES.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 sw  input  8  raw slide switches, asynchronous to clk.
REQ-006 btn  input  5  raw push buttons, asynchronous to clk, 1 = pressed.
REQ-007 port_id  input  8  processor input-port address.
REQ-008 read_strobe  input  1  one-cycle pulse, processor consumes in_port this cycle.
REQ-009 in_port  output  8  registered read data.
REQ-010 interrupt  output  1  level interrupt request to processor.
REQ-011 interrupt_ack  input  1  one-cycle acknowledge from processor.

Function
REQ-012 Each of the 13 raw inputs SHALL pass through a 2-flop synchronizer; the synchronized value is valid 2 cycles after the raw edge.
REQ-013 Per input: when the synchronized value equals the debounced value, the counter SHALL clear to 0; otherwise it SHALL increment, and on the cycle it reaches DB_CYCLES-1 the debounced value SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A glitch shorter than DB_CYCLES cycles SHALL NOT change the debounced value; any return to the debounced level restarts the count from 0.
REQ-015 A 0->1 transition of debounced btn[i] SHALL set sticky bit evt[i] on the following cycle; a 1->0 transition SHALL NOT affect evt.
REQ-016 in_port SHALL be registered every cycle from port_id, independent of read_strobe, with 1-cycle latency: 0x00 -> debounced sw; 0x01 -> {3'b0, debounced btn}; 0x02 -> {3'b0, evt}; any other port_id -> 0x00.
REQ-017 read_strobe=1 with port_id=0x02 SHALL clear exactly those evt bits that are 1 in the current in_port value; bits not returned are unaffected.
REQ-018 Simultaneous set and clear of the same evt bit: set SHALL win (bit stays 1).
REQ-019 Interrupt FSM states IDLE, REQ, WAIT_CLR; interrupt=1 only in REQ.
REQ-020 IDLE -> REQ when evt != 0; REQ -> WAIT_CLR on interrupt_ack=1; WAIT_CLR -> IDLE when evt == 0; REQ holds indefinitely without interrupt_ack.
REQ-021 interrupt_ack in IDLE or WAIT_CLR SHALL be ignored.
REQ-022 New events arriving in WAIT_CLR SHALL NOT re-raise interrupt until evt returns to 0 and the FSM passes through IDLE.

Reset
REQ-023 rst=1 SHALL asynchronously force: synchronizers, debounced values, counters, evt all 0; in_port=0x00; interrupt=0; FSM=IDLE.
REQ-024 Reset asserted mid-debounce or in REQ SHALL abandon the operation; after release, inputs already at 1 SHALL be re-debounced from 0 and a held button SHALL produce one new event.
REQ-025 First clock edge after rst deassertion SHALL be normal operation; no extra settling cycles.

Verification (bench uses DB_CYCLES=4)
REQ-026 rst high 40 ns, sw=0xA5 held -> in_port=0x00 during reset; port_id=0x00 reads 0xA5 no later than 2+4+1 cycles after release.
REQ-027 btn[2] pulsed high for 3 cycles -> debounced btn unchanged, evt=0x00, interrupt stays 0.
REQ-028 btn[0] held high -> evt=0x01, interrupt=1; port_id=0x02 read with read_strobe -> in_port=0x01, evt cleared; interrupt_ack -> interrupt=0, FSM returns to IDLE.
REQ-029 btn[4] rises on the same cycle a port 0x02 read clears evt[4]=1 -> evt[4] remains 1; interrupt re-raises after the WAIT_CLR->IDLE pass.
REQ-030 interrupt=1, rst pulsed -> interrupt=0 immediately (asynchronous); btn[1] held through reset -> exactly one new event after release.
REQ-031 port_id=0x7F with read_strobe -> in_port=0x00, evt unchanged.

Source files
------------

// File: rtl/sw_btn_in.sv
// Switch/button input port: synchronizes and debounces 8 switches and 5 buttons,
// latches button presses as sticky events and raises a level interrupt until acknowledged.
module sw_btn_in #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw,
    input  logic [4:0] btn,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    localparam int              N_IN     = 13;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [7:0]      PORT_SW  = 8'h00;
    localparam logic [7:0]      PORT_BTN = 8'h01;
    localparam logic [7:0]      PORT_EVT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_CLR
    } irq_state_t;

    // Switches occupy bits 7:0, buttons bits 12:8 of every per-input vector.
    logic [N_IN-1:0] raw_in;
    assign raw_in = {btn, sw};

    logic [N_IN-1:0] sync1_q, sync1_d;
    logic [N_IN-1:0] sync2_q, sync2_d;
    logic [N_IN-1:0] db_q;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // One counter per input; it only runs while the synchronized level disagrees
    // with the debounced level, so any return to the old level restarts it.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             db_bit_q, db_bit_d;

            always_comb begin
                cnt_d    = '0;
                db_bit_d = db_bit_q;
                if (sync2_q[gi] != db_bit_q) begin
                    if (cnt_q == CNT_LAST) begin
                        db_bit_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q    <= '0;
                    db_bit_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    db_bit_q <= db_bit_d;
                end
            end

            assign db_q[gi] = db_bit_q;
        end
    endgenerate

    logic [7:0] db_sw;
    logic [4:0] db_btn;
    assign db_sw  = db_q[7:0];
    assign db_btn = db_q[12:8];

    logic [4:0] db_btn_prev_q, db_btn_prev_d;
    logic [4:0] evt_q, evt_d;
    logic [4:0] btn_rise;
    logic [4:0] evt_clr;
    logic [7:0] in_port_q, in_port_d;

    // Clearing uses the value the processor is reading this cycle, so only
    // events it has actually seen are dropped; a simultaneous new rise wins.
    always_comb begin
        db_btn_prev_d = db_btn;
        btn_rise      = db_btn & ~db_btn_prev_q;
        evt_clr       = '0;
        if (read_strobe && (port_id == PORT_EVT)) begin
            evt_clr = in_port_q[4:0];
        end
        evt_d = (evt_q & ~evt_clr) | btn_rise;
    end

    always_comb begin
        in_port_d = 8'h00;
        case (port_id)
            PORT_SW:  in_port_d = db_sw;
            PORT_BTN: in_port_d = {3'b000, db_btn};
            PORT_EVT: in_port_d = {3'b000, evt_q};
            default:  in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_btn_prev_q <= '0;
            evt_q         <= '0;
            in_port_q     <= 8'h00;
        end else begin
            db_btn_prev_q <= db_btn_prev_d;
            evt_q         <= evt_d;
            in_port_q     <= in_port_d;
        end
    end

    assign in_port = in_port_q;

    irq_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // WAIT_CLR keeps the request low until every pending event has been read out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_q != '0) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (interrupt_ack) state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                if (evt_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign interrupt = (state_q == ST_REQ);

endmodule

// File: tb/tb_sw_btn_in.sv
// Bench for sw_btn_in: directed scenarios plus random traffic, every cycle compared
// against a window-based behavioural model of the input port.
module tb_sw_btn_in;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [4:0] btn = 5'h00;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sw_btn_in #(.DB_CYCLES(DB), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .sw           (sw),
        .btn          (btn),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack)
    );

    // Reference model: a level is adopted once the last DB synchronized samples all
    // show the opposite level; sync is the raw input delayed by two clocks.
    logic [12:0] m_s1, m_s2, m_db;
    logic [12:0] m_hist [DB];
    logic [4:0]  m_prev, m_evt;
    logic [7:0]  m_in;
    int          m_st;   // 0 idle, 1 request, 2 waiting for clear

    always @(posedge clk or posedge rst) begin : model
        logic [12:0] old_db, new_db;
        logic [4:0]  old_evt, clr;
        logic [7:0]  old_in;
        bit          all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0; m_evt = '0; m_in = '0; m_st = 0;
            for (int k = 0; k < DB; k++) m_hist[k] = '0;
        end else begin
            old_db = m_db; old_evt = m_evt; old_in = m_in;
            for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = m_s2;
            new_db = old_db;
            for (int b = 0; b < 13; b++) begin
                all_diff = 1'b1;
                for (int k = 0; k < DB; k++) if (m_hist[k][b] == old_db[b]) all_diff = 1'b0;
                if (all_diff) new_db[b] = ~old_db[b];
            end
            m_s2 = m_s1;
            m_s1 = {btn, sw};
            clr  = (read_strobe && port_id == 8'h02) ? old_in[4:0] : 5'h00;
            m_evt = (old_evt & ~clr) | (old_db[12:8] & ~m_prev);
            m_prev = old_db[12:8];
            case (port_id)
                8'h00:   m_in = old_db[7:0];
                8'h01:   m_in = {3'b000, old_db[12:8]};
                8'h02:   m_in = {3'b000, old_evt};
                default: m_in = 8'h00;
            endcase
            case (m_st)
                0:       if (old_evt != 0) m_st = 1;
                1:       if (interrupt_ack) m_st = 2;
                default: if (old_evt == 0) m_st = 0;
            endcase
            m_db = new_db;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic was_read;
        logic [7:0] rd_port;
        was_read = read_strobe;
        rd_port  = port_id;
        @(posedge clk);
        @(negedge clk);
        check("in_port", 32'(in_port), 32'(m_in));
        check("interrupt", 32'(interrupt), 32'(m_st == 1));
        if (was_read) $display("read port=0x%02h data=0x%02h irq=%0d", rd_port, in_port, interrupt);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_irq(input string tag, input int limit);
        int n;
        n = 0;
        while (interrupt !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(tag, 32'(interrupt), 32'd1);
    endtask

    initial begin
        bit found;
        int n;

        // Reset with switches already set, then measure the release latency.
        sw = 8'hA5;
        port_id = 8'h00;
        #12;
        check("rst_in_port", 32'(in_port), 32'h00);
        check("rst_irq", 32'(interrupt), 32'd0);
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("rst_in_port_late", 32'(in_port), 32'h00);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 7 && !found; i++) begin
            tick();
            if (in_port == 8'hA5) found = 1'b1;
        end
        check("sw_release_latency", 32'(found), 32'd1);
        $display("reset release: sw read back 0x%02h", in_port);

        // Three-cycle glitch on btn[2] must be filtered out.
        port_id = 8'h01;
        btn = 5'b00100;
        ticks(3);
        btn = 5'b00000;
        ticks(10);
        check("glitch_btn", 32'(in_port), 32'h00);
        check("glitch_irq", 32'(interrupt), 32'd0);
        port_id = 8'h02;
        ticks(2);
        check("glitch_evt", 32'(in_port), 32'h00);

        // Press btn[0], read and clear the event, acknowledge.
        btn = 5'b00001;
        wait_irq("press0_irq", 20);
        check("press0_evt", 32'(in_port), 32'h01);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
        check("press0_cleared", 32'(in_port), 32'h00);
        check("press0_irq_held", 32'(interrupt), 32'd1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        check("ack_drops_irq", 32'(interrupt), 32'd0);
        btn = 5'b00000;
        ticks(10);
        check("release0_quiet", 32'(interrupt), 32'd0);

        // btn[4]: acknowledge, then a new rise coincides with the clearing read.
        btn = 5'b10000;
        wait_irq("press4_irq", 20);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        btn = 5'b00000;
        ticks(10);
        check("wait_clr_no_irq", 32'(interrupt), 32'd0);
        btn = 5'b10000;
        found = 1'b0;
        n = 0;
        while (!found && n < 20) begin
            if (m_db[12] && !m_prev[4]) begin
                found = 1'b1;
                check("collide_in_port", 32'(in_port[4]), 32'd1);
                read_strobe = 1'b1;
                tick();
                read_strobe = 1'b0;
            end else begin
                tick();
            end
            n++;
        end
        check("collide_found", 32'(found), 32'd1);
        tick();
        check("set_wins", 32'(in_port[4]), 32'd1);
        check("wait_clr_still_low", 32'(interrupt), 32'd0);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        ticks(3);
        check("evt4_cleared", 32'(in_port), 32'h00);
        btn = 5'b11000;
        wait_irq("reraise_irq", 20);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;

        // Unmapped port read must not touch evt.
        port_id = 8'h7F;
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tick();
        check("port7f_zero", 32'(in_port), 32'h00);
        port_id = 8'h02;
        ticks(2);
        check("port7f_evt_kept", 32'(in_port), 32'h08);
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        btn = 5'b00000;
        ticks(12);

        // Asynchronous reset while requesting; btn[1] held across it.
        btn = 5'b00010;
        wait_irq("press1_irq", 20);
        #2 rst = 1'b1;
        #1;
        check("async_rst_irq", 32'(interrupt), 32'd0);
        check("async_rst_in_port", 32'(in_port), 32'h00);
        @(negedge clk);
        tick();
        rst = 1'b0;
        wait_irq("post_rst_irq", 20);
        check("post_rst_evt", 32'(in_port), 32'h02);
        read_strobe = 1'b1;
        interrupt_ack = 1'b1;
        tick();
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;
        ticks(15);
        check("post_rst_single_evt", 32'(in_port), 32'h00);
        check("post_rst_irq_low", 32'(interrupt), 32'd0);
        btn = 5'b00000;
        ticks(10);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) btn = btn ^ 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
            case ($urandom_range(0, 4))
                0:       port_id = 8'h00;
                1:       port_id = 8'h01;
                4:       port_id = 8'($urandom);
                default: port_id = 8'h02;
            endcase
            read_strobe   = ($urandom_range(0, 3) == 0);
            interrupt_ack = ($urandom_range(0, 5) == 0);
            tick();
        end
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
